regfile_wb_arbiter: RTL and testbench

Shares the single write port (WE3/A3/WD3) of the 32×32 register file between two writeback requesters: the ALU result path and the memory-load path. Each requester pushes writes through a valid/ready handshake into its own small FIFO. A round-robin arbiter drains one write per cycle into registered write-port outputs. A hazard-query port tells the decode/stall logic whether a write to a given register is still in flight.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/wb_fifo.sv | 84 ++++++++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path.
// Address/data defaults, the zero register and requester IDs.
package regfile_pkg;

    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;
    localparam int REG_ZERO = 0;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order writeback FIFO holding (address, data) pairs.
// Exposes a per-entry address match vector for hazard queries.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [AW-1:0]    push_addr,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW-1:0]    head_addr,
    output logic [DW-1:0]    head_data,
    input  logic [AW-1:0]    q_addr,
    output logic [DEPTH-1:0] match
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_q[rptr];
    assign head_data = data_q[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PW'(1);
            if (do_pop)
                rptr <= rptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (do_push) begin
            addr_q[wptr] <= push_addr;
            data_q[wptr] <= push_data;
        end
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        logic [PW-1:0] off;
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - rptr;
            match[i] = (CW'(off) < cnt) && (addr_q[i] == q_addr);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port
// between the ALU and load writeback paths.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ALU_VALID,
    output logic          ALU_READY,
    input  logic [AW-1:0] ALU_ADDR,
    input  logic [DW-1:0] ALU_DATA,
    input  logic          MEM_VALID,
    output logic          MEM_READY,
    input  logic [AW-1:0] MEM_ADDR,
    input  logic [DW-1:0] MEM_DATA,
    output logic          WE3,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD3,
    input  logic [AW-1:0] Q_ADDR,
    output logic          Q_HIT,
    output logic          BUSY
);

    logic             alu_full, alu_empty;
    logic             mem_full, mem_empty;
    logic [AW-1:0]    alu_haddr, mem_haddr;
    logic [DW-1:0]    alu_hdata, mem_hdata;
    logic [DEPTH-1:0] alu_match, mem_match;
    logic             alu_push, mem_push;
    logic             gnt_alu, gnt_mem;
    logic             last_q;

    assign ALU_READY = RST_N && !alu_full;
    assign MEM_READY = RST_N && !mem_full;

    // Writes to x0 complete the handshake but never enter a FIFO.
    assign alu_push = ALU_VALID && ALU_READY
                   && (ALU_ADDR != AW'(REG_ZERO));
    assign mem_push = MEM_VALID && MEM_READY
                   && (MEM_ADDR != AW'(REG_ZERO));

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_alu_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (alu_push),
        .push_addr (ALU_ADDR),
        .push_data (ALU_DATA),
        .pop       (gnt_alu),
        .full      (alu_full),
        .empty     (alu_empty),
        .head_addr (alu_haddr),
        .head_data (alu_hdata),
        .q_addr    (Q_ADDR),
        .match     (alu_match)
    );

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (mem_push),
        .push_addr (MEM_ADDR),
        .push_data (MEM_DATA),
        .pop       (gnt_mem),
        .full      (mem_full),
        .empty     (mem_empty),
        .head_addr (mem_haddr),
        .head_data (mem_hdata),
        .q_addr    (Q_ADDR),
        .match     (mem_match)
    );

    // ALU wins when alone or when MEM was granted last.
    assign gnt_alu = !alu_empty
                  && (mem_empty || (last_q == REQ_MEM));
    assign gnt_mem = !mem_empty && !gnt_alu;

    // Registered write port and round-robin history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WE3    <= 1'b0;
            A3     <= '0;
            WD3    <= '0;
            last_q <= REQ_MEM;
        end else begin
            WE3 <= gnt_alu || gnt_mem;
            unique case (1'b1)
                gnt_alu: begin
                    A3     <= alu_haddr;
                    WD3    <= alu_hdata;
                    last_q <= REQ_ALU;
                end
                gnt_mem: begin
                    A3     <= mem_haddr;
                    WD3    <= mem_hdata;
                    last_q <= REQ_MEM;
                end
                default: ;
            endcase
        end
    end

    assign Q_HIT = (Q_ADDR != AW'(REG_ZERO))
                && ((|alu_match) || (|mem_match)
                    || (WE3 && (A3 == Q_ADDR)));

    assign BUSY = !alu_empty || !mem_empty || WE3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Expected values are hand-derived per scenario.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          CLK;
    logic          RST_N;
    logic          ALU_VALID;
    logic          ALU_READY;
    logic [AW-1:0] ALU_ADDR;
    logic [DW-1:0] ALU_DATA;
    logic          MEM_VALID;
    logic          MEM_READY;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [AW-1:0] Q_ADDR;
    logic          Q_HIT;
    logic          BUSY;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ALU_VALID (ALU_VALID),
        .ALU_READY (ALU_READY),
        .ALU_ADDR  (ALU_ADDR),
        .ALU_DATA  (ALU_DATA),
        .MEM_VALID (MEM_VALID),
        .MEM_READY (MEM_READY),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DATA  (MEM_DATA),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .Q_ADDR    (Q_ADDR),
        .Q_HIT     (Q_HIT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ALU_VALID = 1'b0;
        MEM_VALID = 1'b0;
        RST_N     = 1'b0;
        #2;
        chk("rst_alu_rdy", ALU_READY, 0);
        chk("rst_mem_rdy", MEM_READY, 0);
        chk("rst_we3", WE3, 0);
        chk("rst_busy", BUSY, 0);
        step();
        RST_N = 1'b1;
        #1;
    endtask

    logic [AW-1:0] got_q[$];
    logic [AW-1:0] exp_seq [8];
    logic          ar, mr;
    int            ai, mi, idle;
    bit            started;
    logic          rdy_exp [6];

    initial begin
        RST_N     = 1'b0;
        ALU_VALID = 1'b0;
        ALU_ADDR  = '0;
        ALU_DATA  = '0;
        MEM_VALID = 1'b0;
        MEM_ADDR  = '0;
        MEM_DATA  = '0;
        Q_ADDR    = '0;
        step();

        // Single uncontended ALU write.
        do_reset();
        chk("post_we3", WE3, 0);
        chk("post_a3", A3, 0);
        chk("post_wd3", WD3, 0);
        chk("post_busy", BUSY, 0);
        chk("post_qhit", Q_HIT, 0);
        chk("post_alu_rdy", ALU_READY, 1);
        chk("post_mem_rdy", MEM_READY, 1);
        ALU_VALID = 1'b1;
        ALU_ADDR  = 5'd5;
        ALU_DATA  = 32'hDEADBEEF;
        Q_ADDR    = 5'd5;
        step();
        ALU_VALID = 1'b0;
        chk("t1_we3_n", WE3, 0);
        chk("t1_busy_n", BUSY, 1);
        chk("t1_qhit_n", Q_HIT, 1);
        step();
        chk("t1_we3", WE3, 1);
        chk("t1_a3", A3, 5);
        chk("t1_wd3", WD3, 32'hDEADBEEF);
        chk("t1_qhit_we", Q_HIT, 1);
        step();
        chk("t1_we3_done", WE3, 0);
        chk("t1_busy_done", BUSY, 0);
        chk("t1_qhit_done", Q_HIT, 0);

        // Both streams valid every cycle: strict alternation.
        do_reset();
        exp_seq = '{5'd1, 5'd11, 5'd2, 5'd12,
                    5'd3, 5'd13, 5'd4, 5'd14};
        ai = 0;
        mi = 0;
        idle = 0;
        started = 0;
        got_q.delete();
        for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
            ALU_VALID = (ai < 4);
            ALU_ADDR  = AW'(ai + 1);
            ALU_DATA  = 32'hA000 + ai;
            MEM_VALID = (mi < 4);
            MEM_ADDR  = AW'(mi + 11);
            MEM_DATA  = 32'hB000 + mi;
            ar = ALU_READY;
            mr = MEM_READY;
            step();
            if (ALU_VALID && ar) ai++;
            if (MEM_VALID && mr) mi++;
            if (WE3) begin
                got_q.push_back(A3);
                started = 1;
            end else if (started) begin
                idle++;
            end
        end
        ALU_VALID = 1'b0;
        MEM_VALID = 1'b0;
        chk("t2_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_a3_%0d", i),
                (i < got_q.size()) ? got_q[i] : 5'd0,
                exp_seq[i]);
        chk("t2_idle", idle, 0);
        step();
        step();

        // ALU fills while MEM competes; full blocks same-cycle accept.
        do_reset();
        rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ALU_VALID = 1'b1;
        ALU_ADDR  = 5'd20;
        ALU_DATA  = 32'h1;
        MEM_VALID = 1'b1;
        MEM_ADDR  = 5'd25;
        MEM_DATA  = 32'h2;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t3_rdy_%0d", i), ALU_READY, rdy_exp[i]);
        end
        ALU_VALID = 1'b0;
        MEM_VALID = 1'b0;

        // Write to x0 is swallowed.
        do_reset();
        Q_ADDR    = 5'd0;
        ALU_VALID = 1'b1;
        ALU_ADDR  = 5'd0;
        ALU_DATA  = 32'h1234;
        chk("t4_rdy", ALU_READY, 1);
        step();
        ALU_VALID = 1'b0;
        chk("t4_busy", BUSY, 0);
        chk("t4_qhit", Q_HIT, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_we3_%0d", i), WE3, 0);
            step();
        end

        // Hazard window for a load to x7.
        do_reset();
        Q_ADDR    = 5'd7;
        MEM_VALID = 1'b1;
        MEM_ADDR  = 5'd7;
        MEM_DATA  = 32'hCAFE0007;
        chk("t5_qhit_pre", Q_HIT, 0);
        step();
        MEM_VALID = 1'b0;
        chk("t5_qhit_q", Q_HIT, 1);
        chk("t5_we3_q", WE3, 0);
        step();
        chk("t5_we3", WE3, 1);
        chk("t5_a3", A3, 7);
        chk("t5_qhit_w", Q_HIT, 1);
        step();
        chk("t5_qhit_after", Q_HIT, 0);
        chk("t5_we3_after", WE3, 0);

        // Reset mid-operation drops everything.
        do_reset();
        Q_ADDR    = 5'd0;
        ALU_VALID = 1'b1;
        ALU_ADDR  = 5'd3;
        ALU_DATA  = 32'h33;
        MEM_VALID = 1'b1;
        MEM_ADDR  = 5'd13;
        MEM_DATA  = 32'h1313;
        step();
        ALU_ADDR  = 5'd4;
        MEM_ADDR  = 5'd14;
        step();
        ALU_VALID = 1'b0;
        MEM_VALID = 1'b0;
        chk("t6_we3_pre", WE3, 1);
        chk("t6_busy_pre", BUSY, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_we3_rst", WE3, 0);
        chk("t6_busy_rst", BUSY, 0);
        chk("t6_alu_rdy_rst", ALU_READY, 0);
        chk("t6_mem_rdy_rst", MEM_READY, 0);
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_stale_%0d", i), WE3, 0);
        end
        chk("t6_busy_idle", BUSY, 0);
        ALU_VALID = 1'b1;
        ALU_ADDR  = 5'd9;
        ALU_DATA  = 32'h99;
        MEM_VALID = 1'b1;
        MEM_ADDR  = 5'd19;
        MEM_DATA  = 32'h1919;
        step();
        ALU_VALID = 1'b0;
        MEM_VALID = 1'b0;
        step();
        chk("t6_tie_we3", WE3, 1);
        chk("t6_tie_a3", A3, 9);
        chk("t6_tie_wd3", WD3, 32'h99);
        step();
        chk("t6_next_a3", A3, 19);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
